// File: rtl/io_digit_seq_if.sv
// io_digit_seq_if: operator, device and arith_ctrl signals of the digit sequencer
interface io_digit_seq_if;
  logic       start_in_from_op, start_out_from_op, mode_dec_from_op, abort_from_pu;
  logic       in_valid_from_dev, in_ready_to_dev;
  logic [3:0] in_data_from_dev;
  logic       out_valid_to_dev, out_ready_from_dev;
  logic [3:0] out_data_to_dev;
  logic       order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac;
  logic       ac_answer_from_ac, do_left_shift_c_from_ac;
  logic       reg_c1_from_au, output_sign_from_ac, shift_in_bit_to_au;
  logic       load_sign_to_ac, sign_to_ac, io_answer_to_op, busy_to_op;
  modport slave (
    input  start_in_from_op, start_out_from_op, mode_dec_from_op, abort_from_pu,
           in_valid_from_dev, in_data_from_dev, out_ready_from_dev,
           ac_answer_from_ac, do_left_shift_c_from_ac, reg_c1_from_au, output_sign_from_ac,
    output in_ready_to_dev, out_valid_to_dev, out_data_to_dev, order_io_to_ac,
           shift_3_bit_to_ac, shift_4_bit_to_ac, shift_in_bit_to_au,
           load_sign_to_ac, sign_to_ac, io_answer_to_op, busy_to_op
  );
  modport master (
    output start_in_from_op, start_out_from_op, mode_dec_from_op, abort_from_pu,
           in_valid_from_dev, in_data_from_dev, out_ready_from_dev,
           ac_answer_from_ac, do_left_shift_c_from_ac, reg_c1_from_au, output_sign_from_ac,
    input  in_ready_to_dev, out_valid_to_dev, out_data_to_dev, order_io_to_ac,
           shift_3_bit_to_ac, shift_4_bit_to_ac, shift_in_bit_to_au,
           load_sign_to_ac, sign_to_ac, io_answer_to_op, busy_to_op
  );
endinterface

// File: rtl/io_digit_seq.sv
// io_digit_seq: moves one word between C and the I/O devices digit by digit via arith_ctrl shifts
module io_digit_seq (
  input logic       clk,
  input logic       resetn,
  io_digit_seq_if.slave io
);
  localparam logic [7:0] S_IDLE = 8'h01, S_IN_SIGN = 8'h02, S_IN_WAIT = 8'h04, S_IN_SHIFT = 8'h08,
                         S_OUT_SIGN = 8'h10, S_OUT_SHIFT = 8'h20, S_OUT_SEND = 8'h40, S_DONE = 8'h80;
  logic [7:0] state_q, state_d;
  logic       mode_q, mode_d, ord_q, ord_d;
  logic [3:0] cnt_q, cnt_d, dig_q, dig_d;
  logic       in_acc, out_acc;
  logic [3:0] cnt_inc, tgt;
  assign in_acc  = io.in_valid_from_dev & io.in_ready_to_dev;
  assign out_acc = io.out_valid_to_dev & io.out_ready_from_dev;
  assign cnt_inc = cnt_q + 4'd1;
  assign tgt     = mode_q ? 4'd7 : 4'd10;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      ord_q   <= 1'b0;
      cnt_q   <= 4'd0;
      dig_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ord_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mode_d  = (io.start_in_from_op | io.start_out_from_op) ? io.mode_dec_from_op : mode_q;
        cnt_d   = 4'd0;
        dig_d   = 4'd0;
        state_d = io.start_in_from_op ? S_IN_SIGN : io.start_out_from_op ? S_OUT_SIGN : S_IDLE;
      end
      S_IN_SIGN: state_d = in_acc ? S_IN_WAIT : S_IN_SIGN;
      S_IN_WAIT: if (in_acc) begin
        // octal digits are left-aligned so the first shift always emits the digit MSB
        dig_d   = mode_q ? io.in_data_from_dev : {io.in_data_from_dev[2:0], 1'b0};
        ord_d   = 1'b1;
        state_d = S_IN_SHIFT;
      end
      S_IN_SHIFT: begin
        dig_d = io.do_left_shift_c_from_ac ? {dig_q[2:0], 1'b0} : dig_q;
        if (io.ac_answer_from_ac) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == tgt) ? S_DONE : S_IN_WAIT;
        end
      end
      S_OUT_SIGN: if (out_acc) begin
        dig_d   = 4'd0;
        ord_d   = 1'b1;
        state_d = S_OUT_SHIFT;
      end
      S_OUT_SHIFT: begin
        dig_d   = io.do_left_shift_c_from_ac ? {dig_q[2:0], io.reg_c1_from_au} : dig_q;
        state_d = io.ac_answer_from_ac ? S_OUT_SEND : S_OUT_SHIFT;
      end
      S_OUT_SEND: if (out_acc) begin
        cnt_d   = cnt_inc;
        dig_d   = 4'd0;
        ord_d   = cnt_inc != tgt;
        state_d = (cnt_inc == tgt) ? S_DONE : S_OUT_SHIFT;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (io.abort_from_pu) begin
      state_d = S_IDLE;
      ord_d   = 1'b0;
    end
  end
  always_comb begin
    io.busy_to_op         = state_q != S_IDLE;
    io.shift_3_bit_to_ac  = io.busy_to_op & ~mode_q;
    io.shift_4_bit_to_ac  = io.busy_to_op & mode_q;
    io.in_ready_to_dev    = (state_q == S_IN_SIGN) | (state_q == S_IN_WAIT);
    io.load_sign_to_ac    = (state_q == S_IN_SIGN) & io.in_valid_from_dev & ~io.abort_from_pu;
    io.sign_to_ac         = io.load_sign_to_ac & io.in_data_from_dev[0];
    io.out_valid_to_dev   = (state_q == S_OUT_SIGN) | (state_q == S_OUT_SEND);
    io.out_data_to_dev    = (state_q == S_OUT_SIGN) ? {3'b0, io.output_sign_from_ac} :
                            (state_q == S_OUT_SEND) ? (mode_q ? dig_q : {1'b0, dig_q[2:0]}) : 4'd0;
    io.shift_in_bit_to_au = (state_q == S_IN_SHIFT) & dig_q[3];
    io.order_io_to_ac     = ord_q;
    io.io_answer_to_op    = (state_q == S_DONE) & ~io.abort_from_pu;
  end
endmodule

// File: tb/tb_io_digit_seq.sv
// tb_io_digit_seq: scoreboard bench playing operator, devices and arith_ctrl around io_digit_seq
module tb_io_digit_seq;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  io_digit_seq_if b();
  io_digit_seq dut (.clk(clk), .resetn(resetn), .io(b));
  int total = 0, bad = 0, orders = 0, answers = 0;
  logic exp_bits[$];
  logic cbits[$];
  logic [3:0] exp_dig[$];
  always @(negedge clk) begin
    #2;
    if (b.order_io_to_ac) orders++;
    if (b.io_answer_to_op) answers++;
  end
  function automatic logic [13:0] outs();
    return {b.busy_to_op, b.shift_3_bit_to_ac, b.shift_4_bit_to_ac, b.in_ready_to_dev,
            b.out_valid_to_dev, b.out_data_to_dev, b.order_io_to_ac, b.io_answer_to_op,
            b.load_sign_to_ac, b.sign_to_ac, b.shift_in_bit_to_au};
  endfunction
  task automatic dev_send(input logic [3:0] d, output logic ls, output logic sg);
    bit ok;
    ok = 0; ls = 0; sg = 0;
    b.in_valid_from_dev = 1; b.in_data_from_dev = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = b.in_ready_to_dev; ls = b.load_sign_to_ac; sg = b.sign_to_ac;
      @(negedge clk);
    end
    b.in_valid_from_dev = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL in_accept: ready never seen, got=0 exp=1"); end
  endtask
  task automatic ac_seq(input int k, input bit outm);
    int n;
    logic e;
    n = 0;
    while (!b.order_io_to_ac && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!b.order_io_to_ac) begin bad++; $display("FAIL order_io: got=0 exp=1 (timeout)"); end
    @(negedge clk);
    for (int i = 0; i < k; i++) begin
      b.do_left_shift_c_from_ac = 1;
      if (outm) b.reg_c1_from_au = cbits.size() ? cbits.pop_front() : 1'b0;
      else begin
        e = exp_bits.size() ? exp_bits.pop_front() : 1'bx;
        #1; total++;
        if (b.shift_in_bit_to_au !== e) begin
          bad++; $display("FAIL shift_in bit %0d: got=%b exp=%b", i, b.shift_in_bit_to_au, e);
        end
      end
      @(negedge clk);
      b.do_left_shift_c_from_ac = 0;
    end
    b.ac_answer_from_ac = 1; @(negedge clk); b.ac_answer_from_ac = 0;
  endtask
  task automatic dev_recv(input int stall);
    int n;
    logic [3:0] held, e;
    n = 0;
    #1;
    while (!b.out_valid_to_dev && n < 100) begin @(negedge clk); #1; n++; end
    total++;
    if (!b.out_valid_to_dev) begin bad++; $display("FAIL out_valid: got=0 exp=1 (timeout)"); end
    held = b.out_data_to_dev;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1; total++;
      if (!b.out_valid_to_dev || b.out_data_to_dev !== held || b.order_io_to_ac) begin
        bad++; $display("FAIL stall hold: got v=%b d=%h o=%b exp v=1 d=%h o=0",
                        b.out_valid_to_dev, b.out_data_to_dev, b.order_io_to_ac, held);
      end
    end
    b.out_ready_from_dev = 1;
    e = exp_dig.size() ? exp_dig.pop_front() : 4'hx;
    total++;
    if (b.out_data_to_dev !== e) begin bad++; $display("FAIL out_data: got=%h exp=%h", b.out_data_to_dev, e); end
    @(negedge clk);
    b.out_ready_from_dev = 0;
  endtask
  task automatic start_op(input bit md, input bit inp);
    b.mode_dec_from_op = md;
    if (inp) b.start_in_from_op = 1; else b.start_out_from_op = 1;
    @(negedge clk);
    b.start_in_from_op = 0; b.start_out_from_op = 0; b.mode_dec_from_op = ~md;
    #1; total++;
    if ({b.busy_to_op, b.shift_3_bit_to_ac, b.shift_4_bit_to_ac} !== {1'b1, ~md, md}) begin
      bad++; $display("FAIL start busy/shift: got=%b exp=%b",
                      {b.busy_to_op, b.shift_3_bit_to_ac, b.shift_4_bit_to_ac}, {1'b1, ~md, md});
    end
  endtask
  task automatic run_in(input bit md, input logic sg, input logic [3:0] dg[$]);
    logic ls, s;
    logic [3:0] d;
    int o0, a0, nb;
    @(negedge clk);
    o0 = orders; a0 = answers; nb = md ? 4 : 3;
    start_op(md, 1);
    dev_send({3'b101, sg}, ls, s);
    total++;
    if ({ls, s} !== {1'b1, sg}) begin bad++; $display("FAIL load_sign: got=%b exp=%b", {ls, s}, {1'b1, sg}); end
    foreach (dg[i]) begin
      d = dg[i];
      for (int j = nb - 1; j >= 0; j--) exp_bits.push_back(d[j]);
      dev_send(d, ls, s);
      ac_seq(nb, 0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (answers - a0 != 1 || orders - o0 != dg.size() || b.busy_to_op !== 1'b0 || exp_bits.size() != 0) begin
      bad++; $display("FAIL in end: got ans=%0d ord=%0d busy=%b left=%0d exp ans=1 ord=%0d busy=0 left=0",
                      answers - a0, orders - o0, b.busy_to_op, exp_bits.size(), dg.size());
    end
  endtask
  task automatic run_out(input bit md, input logic sg, input logic [3:0] dg[$], input int stall_at);
    logic [3:0] d;
    int o0, a0, nb;
    @(negedge clk);
    o0 = orders; a0 = answers; nb = md ? 4 : 3;
    exp_dig.push_back({3'b0, sg});
    foreach (dg[i]) begin
      d = dg[i];
      exp_dig.push_back(md ? d : {1'b0, d[2:0]});
      for (int j = nb - 1; j >= 0; j--) cbits.push_back(d[j]);
    end
    b.output_sign_from_ac = sg;
    start_op(md, 0);
    dev_recv(stall_at == 0 ? 5 : 0);
    foreach (dg[i]) begin
      ac_seq(nb, 1);
      dev_recv(stall_at == i + 1 ? 5 : 0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (answers - a0 != 1 || orders - o0 != dg.size() || b.busy_to_op !== 1'b0 || exp_dig.size() != 0) begin
      bad++; $display("FAIL out end: got ans=%0d ord=%0d busy=%b left=%0d exp ans=1 ord=%0d busy=0 left=0",
                      answers - a0, orders - o0, b.busy_to_op, exp_dig.size(), dg.size());
    end
  endtask
  task automatic test_reset();
    resetn = 0;
    repeat (2) @(negedge clk);
    #1; total++;
    if (outs() !== 14'd0) begin bad++; $display("FAIL reset outs: got=%b exp=0", outs()); end
    resetn = 1;
    b.do_left_shift_c_from_ac = 1; b.ac_answer_from_ac = 1;
    @(negedge clk);
    b.do_left_shift_c_from_ac = 0; b.ac_answer_from_ac = 0;
    #1; total++;
    if (outs() !== 14'd0) begin bad++; $display("FAIL idle stray: got=%b exp=0", outs()); end
  endtask
  task automatic test_octal_in();
    logic [3:0] dg[$];
    dg = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
    run_in(0, 1, dg);
    dg.delete();
    for (int i = 0; i < 10; i++) dg.push_back(4'($urandom_range(0, 15)));
    run_in(0, 0, dg);
  endtask
  task automatic test_dec_in();
    logic [3:0] dg[$];
    for (int i = 0; i < 7; i++) dg.push_back(4'($urandom_range(0, 15)));
    run_in(1, 1, dg);
  endtask
  task automatic test_dec_out();
    logic [3:0] dg[$];
    dg = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_out(1, 0, dg, -1);
  endtask
  task automatic test_backpressure();
    logic [3:0] dg[$];
    dg = '{4'hB};
    for (int i = 0; i < 9; i++) dg.push_back(4'($urandom_range(0, 7)));
    run_out(0, 1, dg, 2);
    dg.delete();
    for (int i = 0; i < 7; i++) dg.push_back(4'($urandom_range(0, 15)));
    run_out(1, 1, dg, 0);
  endtask
  task automatic test_both_start();
    int a0;
    @(negedge clk);
    a0 = answers;
    b.mode_dec_from_op = 1; b.start_in_from_op = 1; b.start_out_from_op = 1;
    @(negedge clk);
    b.start_in_from_op = 0; b.start_out_from_op = 0;
    #1; total++;
    if ({b.busy_to_op, b.in_ready_to_dev, b.out_valid_to_dev} !== 3'b110) begin
      bad++; $display("FAIL both start: got=%b exp=110", {b.busy_to_op, b.in_ready_to_dev, b.out_valid_to_dev});
    end
    @(negedge clk);
    b.abort_from_pu = 1; @(negedge clk); b.abort_from_pu = 0;
    #1; total++;
    if (b.busy_to_op !== 1'b0 || answers != a0) begin
      bad++; $display("FAIL both abort: got busy=%b ans=%0d exp busy=0 ans=%0d", b.busy_to_op, answers, a0);
    end
  endtask
  task automatic test_abort();
    logic [3:0] dg[$];
    logic ls, s;
    logic [3:0] d;
    int a0;
    @(negedge clk);
    a0 = answers;
    dg = '{4'd3, 4'd6, 4'd1, 4'd4};
    start_op(0, 1);
    dev_send(4'd1, ls, s);
    foreach (dg[i]) begin
      d = dg[i];
      for (int j = 2; j >= 0; j--) exp_bits.push_back(d[j]);
      dev_send(d, ls, s);
      ac_seq(3, 0);
    end
    dev_send(4'd2, ls, s);
    b.do_left_shift_c_from_ac = 1; b.abort_from_pu = 1;
    @(negedge clk);
    b.do_left_shift_c_from_ac = 0; b.abort_from_pu = 0;
    #1; total++;
    if ({b.busy_to_op, b.in_ready_to_dev, b.shift_in_bit_to_au} !== 3'b000) begin
      bad++; $display("FAIL abort idle: got=%b exp=000", {b.busy_to_op, b.in_ready_to_dev, b.shift_in_bit_to_au});
    end
    repeat (3) @(negedge clk);
    total++;
    if (answers != a0 || exp_bits.size() != 0) begin
      bad++; $display("FAIL abort answer: got ans=%0d left=%0d exp ans=%0d left=0", answers, exp_bits.size(), a0);
    end
    dg = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
    run_out(1, 1, dg, 3);
  endtask
  task automatic test_reset_mid();
    int a0;
    @(negedge clk);
    a0 = answers;
    exp_dig.push_back(4'd0);
    cbits = '{1'b0, 1'b1, 1'b1, 1'b0};
    b.output_sign_from_ac = 0;
    start_op(1, 0);
    dev_recv(0);
    ac_seq(4, 1);
    #1; total++;
    if ({b.out_valid_to_dev, b.out_data_to_dev} !== 5'b10110) begin
      bad++; $display("FAIL pre-reset send: got=%b exp=10110", {b.out_valid_to_dev, b.out_data_to_dev});
    end
    resetn = 0;
    @(negedge clk);
    #1; total++;
    if (outs() !== 14'd0) begin bad++; $display("FAIL mid reset outs: got=%b exp=0", outs()); end
    resetn = 1;
    b.ac_answer_from_ac = 1; @(negedge clk); b.ac_answer_from_ac = 0;
    b.do_left_shift_c_from_ac = 1; @(negedge clk); b.do_left_shift_c_from_ac = 0;
    repeat (2) @(negedge clk);
    #1; total++;
    if (outs() !== 14'd0 || answers != a0) begin
      bad++; $display("FAIL post reset stray: got=%b ans=%0d exp=0 ans=%0d", outs(), answers, a0);
    end
    exp_dig.delete(); cbits.delete();
  endtask
  initial begin
    b.start_in_from_op = 0; b.start_out_from_op = 0; b.mode_dec_from_op = 0; b.abort_from_pu = 0;
    b.in_valid_from_dev = 0; b.in_data_from_dev = 0; b.out_ready_from_dev = 0;
    b.ac_answer_from_ac = 0; b.do_left_shift_c_from_ac = 0; b.reg_c1_from_au = 0; b.output_sign_from_ac = 0;
    test_reset();
    test_octal_in();
    test_dec_in();
    test_dec_out();
    test_backpressure();
    test_both_start();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
